// File: rtl/lbp_engine.sv
// rtl/lbp_engine.sv - 3x3 local binary pattern engine with streaming pixel reads and result writes
module lbp_engine #(
    parameter int IMG_W       = 128,
    parameter int IMG_H       = 128,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 14,
    parameter int BORDER_ZERO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] thresh,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic              gray_ready,
    input  logic [DATA_W-1:0] gray_data,
    output logic              lbp_valid,
    input  logic              lbp_ready,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              busy,
    output logic              finish
);
    typedef enum logic [2:0] {IDLE, FETCH, CALC, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO_A     = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] THREE_A   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] W2_A      = ADDR_W'(2 * IMG_W);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] EDGE_COL  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] EDGE_ROW  = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    state_t state, state_nx;

    // win[r*3+c] holds the 3x3 window; win[4] is the center pixel
    logic [DATA_W-1:0] win [9];
    logic [ADDR_W-1:0] row, col, ca, brow, bcol;
    logic [ADDR_W-1:0] row_off, col_off;
    logic [3:0]        rd_idx, pend_slot, slot;
    logic              first, rd_done, pend, border_ph, mode_l;
    logic [DATA_W-1:0] thresh_l;
    logic [DATA_W:0]   thr;
    logic [7:0]        code;
    logic              accept, last_read, xfer, last_center, start_ok, mid_row;

    assign start_ok    = start && (state == IDLE || state == DONE);
    assign gray_req    = (state == FETCH) && !rd_done;
    assign accept      = gray_req && gray_ready;
    assign lbp_valid   = (state == WRITE);
    assign xfer        = lbp_valid && lbp_ready;
    assign busy        = (state == FETCH) || (state == CALC) || (state == WRITE);
    assign finish      = (state == DONE);
    assign slot        = first ? rd_idx : (rd_idx * 4'd3 + 4'd2);
    assign last_read   = first ? (rd_idx == 4'd8) : (rd_idx == 4'd2);
    assign last_center = (row == LAST_ROW) && (col == LAST_COL);
    assign mid_row     = (brow != '0) && (brow != EDGE_ROW);

    // Window slot to read address, relative to the top-left pixel of the window
    always_comb begin
        row_off = '0;
        col_off = '0;
        case (slot)
            4'd3, 4'd4, 4'd5: row_off = W_A;
            4'd6, 4'd7, 4'd8: row_off = W2_A;
            default:          row_off = '0;
        endcase
        case (slot)
            4'd1, 4'd4, 4'd7: col_off = ONE_A;
            4'd2, 4'd5, 4'd8: col_off = TWO_A;
            default:          col_off = '0;
        endcase
        gray_addr = gray_req ? (ca - W_A - ONE_A + row_off + col_off) : '0;
    end

    // LBP code; the threshold sum carries one extra bit so it never wraps
    always_comb begin
        thr     = {1'b0, win[4]} + (mode_l ? {1'b0, thresh_l} : '0);
        code    = '0;
        code[0] = ({1'b0, win[0]} >= thr);
        code[1] = ({1'b0, win[1]} >= thr);
        code[2] = ({1'b0, win[2]} >= thr);
        code[3] = ({1'b0, win[3]} >= thr);
        code[4] = ({1'b0, win[5]} >= thr);
        code[5] = ({1'b0, win[6]} >= thr);
        code[6] = ({1'b0, win[7]} >= thr);
        code[7] = ({1'b0, win[8]} >= thr);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = FETCH;
            FETCH: if (rd_done) state_nx = CALC;
            CALC:  state_nx = WRITE;
            WRITE: begin
                if (xfer) begin
                    if (border_ph) begin
                        if (lbp_addr == LAST_ADDR) state_nx = DONE;
                    end else if (last_center) begin
                        if (BORDER_ZERO == 0) state_nx = DONE;
                    end else begin
                        state_nx = FETCH;
                    end
                end
            end
            DONE:  if (start) state_nx = FETCH;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: window fill/shift, center and border address walk, result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
            row <= '0; col <= '0; ca <= '0; brow <= '0; bcol <= '0;
            rd_idx <= '0; pend_slot <= '0; first <= 1'b0; rd_done <= 1'b0;
            pend <= 1'b0; border_ph <= 1'b0; mode_l <= 1'b0; thresh_l <= '0;
            lbp_addr <= '0; lbp_data <= '0;
        end else if (start_ok) begin
            mode_l <= mode; thresh_l <= thresh;
            row <= ONE_A; col <= ONE_A; ca <= W_A + ONE_A;
            first <= 1'b1; rd_idx <= '0; rd_done <= 1'b0; pend <= 1'b0;
            border_ph <= 1'b0;
        end else begin
            if (state == FETCH) begin
                if (pend) win[pend_slot] <= gray_data;
                pend <= accept;
                if (accept) begin
                    pend_slot <= slot;
                    rd_idx    <= rd_idx + 4'd1;
                    if (last_read) rd_done <= 1'b1;
                end
            end
            if (state == CALC) begin
                lbp_data <= code;
                lbp_addr <= ca;
            end
            if (xfer) begin
                if (border_ph) begin
                    if (mid_row && bcol == '0) begin
                        bcol     <= EDGE_COL;
                        lbp_addr <= lbp_addr + EDGE_COL;
                    end else begin
                        lbp_addr <= lbp_addr + ONE_A;
                        if (bcol == EDGE_COL) begin
                            bcol <= '0;
                            brow <= brow + ONE_A;
                        end else begin
                            bcol <= bcol + ONE_A;
                        end
                    end
                end else if (last_center) begin
                    if (BORDER_ZERO != 0) begin
                        border_ph <= 1'b1;
                        brow <= '0; bcol <= '0;
                        lbp_addr <= '0; lbp_data <= '0;
                    end
                end else begin
                    rd_idx <= '0; rd_done <= 1'b0; pend <= 1'b0;
                    if (col == LAST_COL) begin
                        row <= row + ONE_A; col <= ONE_A;
                        ca <= ca + THREE_A; first <= 1'b1;
                    end else begin
                        col <= col + ONE_A; ca <= ca + ONE_A; first <= 1'b0;
                        win[0] <= win[1]; win[1] <= win[2];
                        win[3] <= win[4]; win[4] <= win[5];
                        win[6] <= win[7]; win[7] <= win[8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lbp_engine.sv
// tb/tb_lbp_engine.sv - randomized self-checking bench for lbp_engine against a pixel-level model
module tb_lbp_engine;
    localparam int W  = 6;
    localparam int H  = 5;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] thresh = '0;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic          gray_ready = 1'b0;
    logic [DW-1:0] gray_data = '0;
    logic          lbp_valid;
    logic          lbp_ready = 1'b0;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          busy;
    logic          finish;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [W*H];
    int got_a[$];
    int got_d[$];
    int rd_cnt = 0;
    bit stall_en = 1'b0;

    always #5 clk = ~clk;

    lbp_engine #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .ADDR_W(AW), .BORDER_ZERO(1)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .thresh(thresh),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_ready(gray_ready), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_ready(lbp_ready), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
        .busy(busy), .finish(finish)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_code(int a, bit m, int th);
        int offs[8];
        int t;
        int c;
        offs = '{-W-1, -W, -W+1, -1, 1, W-1, W, W+1};
        t = int'(mem[a]) + (m ? th : 0);
        c = 0;
        for (int i = 0; i < 8; i++)
            if (int'(mem[a + offs[i]]) >= t) c |= (1 << i);
        return c;
    endfunction

    // Memory responder, random backpressure, handshake stability and transfer capture
    initial begin
        bit pa, pv, pg;
        int paddr;
        logic [AW-1:0] pva, pga;
        logic [7:0] pvd;
        pa = 0; pv = 0; pg = 0; paddr = 0; pva = '0; pga = '0; pvd = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pa = 0; pv = 0; pg = 0;
            end else begin
                if (pa) begin
                    gray_data = mem[paddr];
                    rd_cnt++;
                end else begin
                    gray_data = DW'($urandom);
                end
                if (pv) begin
                    check("hold_valid", lbp_valid, 1);
                    check("hold_addr", lbp_addr, pva);
                    check("hold_data", lbp_data, pvd);
                end
                if (pg) begin
                    check("hold_req", gray_req, 1);
                    check("hold_gaddr", gray_addr, pga);
                end
                gray_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                lbp_ready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                pa = gray_req && gray_ready;
                paddr = int'(gray_addr);
                pg = gray_req && !gray_ready;
                pga = gray_addr;
                pv = lbp_valid && !lbp_ready;
                pva = lbp_addr;
                pvd = lbp_data;
                if (lbp_valid && lbp_ready) begin
                    got_a.push_back(int'(lbp_addr));
                    got_d.push_back(int'(lbp_data));
                end
            end
        end
    end

    task automatic run_frame(input bit m, input int th, input bit poke_start);
        int exp_a[$];
        int exp_d[$];
        int cyc;
        int n;
        for (int r = 1; r <= H-2; r++)
            for (int c = 1; c <= W-2; c++) begin
                exp_a.push_back(r*W + c);
                exp_d.push_back(ref_code(r*W + c, m, th));
            end
        for (int a = 0; a < W*H; a++)
            if (a / W == 0 || a / W == H-1 || a % W == 0 || a % W == W-1) begin
                exp_a.push_back(a);
                exp_d.push_back(0);
            end
        got_a.delete();
        got_d.delete();
        rd_cnt = 0;
        @(negedge clk);
        mode = m; thresh = DW'(th); start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = ~m; thresh = DW'($urandom);
        check("busy_after_start", busy, 1);
        check("finish_cleared", finish, 0);
        cyc = 0;
        while (!finish && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = (poke_start && cyc == 20);
        end
        start = 1'b0;
        check("frame_done_in_budget", (cyc < 5000), 1);
        check("write_count", got_a.size(), exp_a.size());
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            check("lbp_addr", got_a[i], exp_a[i]);
            check("lbp_data", got_d[i], exp_d[i]);
        end
        check("read_count", rd_cnt, (H-2) * (9 + 3*(W-3)));
        check("done_finish", finish, 1);
        check("done_busy", busy, 0);
        check("done_req", gray_req, 0);
        check("done_valid", lbp_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, gray_req, 0);
        check({tag, "_gaddr"}, gray_addr, 0);
        check({tag, "_valid"}, lbp_valid, 0);
        check({tag, "_laddr"}, lbp_addr, 0);
        check({tag, "_ldata"}, lbp_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_finish"}, finish, 0);
    endtask

    task automatic fill_random();
        for (int a = 0; a < W*H; a++) mem[a] = 8'($urandom);
    endtask

    initial begin
        int cyc;
        fill_random();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Known window around center (1,1), address W+1
        mem[0] = 10; mem[1] = 60; mem[2] = 50;
        mem[W] = 40; mem[W+1] = 50; mem[W+2] = 70;
        mem[2*W] = 30; mem[2*W+1] = 80; mem[2*W+2] = 20;
        run_frame(1'b0, 0, 1'b0);
        check("dir_addr", (got_a.size() > 0) ? got_a[0] : -1, W+1);
        check("dir_mode0", (got_d.size() > 0) ? got_d[0] : -1, 8'h56);
        run_frame(1'b1, 15, 1'b0);
        check("dir_mode1", (got_d.size() > 0) ? got_d[0] : -1, 8'h50);
        mem[W+1] = 250;
        for (int i = 0; i < 3; i++) begin
            mem[i] = 255; mem[2*W+i] = 255;
        end
        mem[W] = 255; mem[W+2] = 255;
        run_frame(1'b1, 10, 1'b0);
        check("dir_nowrap", (got_d.size() > 0) ? got_d[0] : -1, 8'h00);

        // Random images, modes, thresholds and stalls; one frame has a stray start
        stall_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            fill_random();
            run_frame(1'($urandom), (f == 4) ? 255 : int'($urandom_range(0, 255)), (f == 2));
        end

        // Reset while fetching center 3, then a fresh frame
        stall_en = 1'b0;
        got_a.delete();
        got_d.delete();
        rd_cnt = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rd_cnt < 13 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_center3", (cyc < 2000), 1);
        check("pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        fill_random();
        run_frame(1'b0, 0, 1'b0);
        check("restart_first_addr", (got_a.size() > 0) ? got_a[0] : -1, W+1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
